// File: rtl/axi_mem_rd_slave.sv
// AXI read responder: accepts one AR burst at a time and returns R beats from an internal word memory.
// Latency: first R beat is valid the cycle after the AR handshake; one beat per cycle with rready high.
// Backpressure: R outputs hold while rvalid && !rready; arready is low for the whole burst.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ar*               AXI read-address channel (slave side)
//   r*                AXI read-data channel (slave side)
//   ld_we/addr/data   side load port, writes one memory word per cycle in any state
//
// Optional feature: define AXI_RD_SLV_WRAP_EN to support WRAP bursts. Without it,
// arburst==2'b10 is reserved and the burst answers SLVERR on every beat.
module axi_mem_rd_slave #(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   localparam int         AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    arid,
   input  logic [31:0]   araddr,
   input  logic [7:0]    arlen,
   input  logic [2:0]    arsize,
   input  logic [1:0]    arburst,
   input  logic          arvalid,
   output logic          arready,
   output logic [3:0]    rid,
   output logic [31:0]   rdata,
   output logic [1:0]    rresp,
   output logic          rlast,
   output logic          rvalid,
   input  logic          rready,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data
);

   localparam logic [1:0]  BT_FIXED  = 2'b00;
   localparam logic [1:0]  BT_INCR   = 2'b01;
   localparam logic [1:0]  BT_WRAP   = 2'b10;
   localparam logic [1:0]  RESP_OK   = 2'b00;
   localparam logic [1:0]  RESP_SLV  = 2'b10;
   // Byte span of the memory, one bit wider so large depths cannot overflow.
   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  id_q, id_d;
   logic [7:0]  len_q, len_d;
   logic [1:0]  burst_q, burst_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;

   // Memory is intentionally not reset so preloaded images survive rst.
   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Address decode for the beat currently presented.
   logic [31:0]   off;
   logic          in_range;
   logic [AW-1:0] idx;
   assign off      = addr_q - BASE_ADDR;
   assign in_range = ({1'b0, off} < MEM_BYTES);
   assign idx      = off[AW+1:2];

   // Burst legality check on the incoming AR.
   logic err_ar;
   always_comb begin
      err_ar = (arsize != 3'd2) || (arburst == 2'b11) || (araddr[1:0] != 2'b00);
`ifdef AXI_RD_SLV_WRAP_EN
      if ((arburst == BT_WRAP) && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
         err_ar = 1'b1;
      end
`else
      if (arburst == BT_WRAP) begin
         err_ar = 1'b1;
      end
`endif
   end

   // Next beat address. WRAP keeps the bits above the (len+1)*4 block and
   // lets only the low bits roll over; len is one of 1/3/7/15 for legal bursts.
   logic [31:0] addr_inc;
   logic [31:0] wrap_mask;
   logic [31:0] addr_nxt;
   assign addr_inc  = addr_q + 32'd4;
   assign wrap_mask = {22'd0, len_q, 2'b11};
   always_comb begin
      addr_nxt = addr_inc;
      case (burst_q)
         BT_FIXED: addr_nxt = addr_q;
         BT_INCR:  addr_nxt = addr_inc;
         BT_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
         default:  addr_nxt = addr_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= 4'd0;
         len_q   <= 8'd0;
         burst_q <= BT_FIXED;
         addr_q  <= 32'd0;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      len_d   = len_q;
      burst_d = burst_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      arready = 1'b0;
      rvalid  = 1'b0;
      rid     = 4'd0;
      rdata   = 32'd0;
      rresp   = RESP_OK;
      rlast   = 1'b0;

      case (state_q)
         IDLE: begin
            // Held low while rst is asserted so nothing is accepted in the reset cycle.
            arready = !rst;
            if (arvalid && arready) begin
               id_d    = arid;
               len_d   = arlen;
               burst_d = arburst;
               addr_d  = araddr;
               cnt_d   = 8'd0;
               err_d   = err_ar;
               state_d = BURST;
            end
         end
         BURST: begin
            rvalid = 1'b1;
            rid    = id_q;
            rlast  = (cnt_q == len_q);
            if (err_q || !in_range) begin
               rresp = RESP_SLV;
            end else begin
               rdata = mem[idx];
            end
            if (rready) begin
               cnt_d  = cnt_q + 8'd1;
               addr_d = addr_nxt;
               if (rlast) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_mem_rd_slave.sv
// Directed bench for axi_mem_rd_slave: burst types, error beats, stalls, load port, reset.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected beats come from hand-computed tables filled before each burst.
module tb_axi_mem_rd_slave;

   localparam int          MEM_WORDS = 4096;
   localparam logic [31:0] BASE      = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        ld_we;
   logic [11:0] ld_addr;
   logic [31:0] ld_data;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_dat [256];
   logic [1:0]  exp_rsp [256];

   axi_mem_rd_slave #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = 12'(idx);
      ld_data = d;
      @(posedge clk); #1;
      ld_we   = 1'b0;
   endtask

   task automatic set_exp(input int i, input logic [31:0] d, input logic [1:0] r);
      exp_dat[i] = d;
      exp_rsp[i] = r;
   endtask

   task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt);
      int w = 0;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = bt;
      arvalid = 1'b1;
      while (!arready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ar_accept", 32'(arready), 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   // Collects nb beats of a tot-beat burst, checking every cycle against the tables.
   task automatic run_burst(input logic [3:0] id, input int nb, input int tot,
                            input bit stall, input string tag);
      int beat = 0;
      int cyc  = 0;
      bit held = 1'b0;
      logic [31:0] hd;
      logic [1:0]  hr;
      logic        hl;
      while (beat < nb && cyc < 1000) begin
         rready = stall ? (cyc % 3 == 0) : 1'b1;
         @(negedge clk);
         chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
         chk({tag, "_arready_busy"}, 32'(arready), 32'd0);
         if (held) begin
            chk({tag, "_stall_dat"}, rdata, hd);
            chk({tag, "_stall_rsp"}, 32'(rresp), 32'(hr));
            chk({tag, "_stall_last"}, 32'(rlast), 32'(hl));
         end
         if (rvalid && rready) begin
            chk({tag, "_rid"}, 32'(rid), 32'(id));
            chk({tag, "_dat"}, rdata, exp_dat[beat]);
            chk({tag, "_rsp"}, 32'(rresp), 32'(exp_rsp[beat]));
            chk({tag, "_last"}, 32'(rlast), 32'(beat == tot - 1));
            beat++;
            held = 1'b0;
         end else if (rvalid) begin
            held = 1'b1;
            hd = rdata; hr = rresp; hl = rlast;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rready = 1'b0;
      if (beat < nb) chk({tag, "_timeout_beats"}, 32'(beat), 32'(nb));
      if (nb == tot) begin
         @(negedge clk);
         chk({tag, "_end_arready"}, 32'(arready), 32'd1);
         chk({tag, "_end_rvalid"}, 32'(rvalid), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b0; rready = 1'b0; ld_we = 1'b0; ld_addr = 12'd0; ld_data = 32'd0;

      @(negedge clk);
      chk("rst_arready", 32'(arready), 32'd0);
      @(posedge clk); #1;
      // Load port works while in reset.
      for (int i = 0; i < 16; i++) preload(i, 32'h1000 + 32'(i));
      preload(MEM_WORDS - 2, 32'hAAAA_0FFE);
      preload(MEM_WORDS - 1, 32'hAAAA_0FFF);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_arready", 32'(arready), 32'd1);
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);
      chk("post_rst_rlast", 32'(rlast), 32'd0);
      chk("post_rst_rid", 32'(rid), 32'd0);
      chk("post_rst_rresp", 32'(rresp), 32'd0);
      chk("post_rst_rdata", rdata, 32'd0);
      @(posedge clk); #1;

      // 16-beat INCR, no backpressure.
      for (int i = 0; i < 16; i++) set_exp(i, 32'h1000 + 32'(i), 2'b00);
      issue_ar(4'd3, BASE, 8'd15, 3'd2, 2'b01);
      run_burst(4'd3, 16, 16, 1'b0, "incr16");

      // Same burst with rready 1,0,0,1,...
      issue_ar(4'd5, BASE, 8'd15, 3'd2, 2'b01);
      run_burst(4'd5, 16, 16, 1'b1, "incr16_stall");

      // WRAP 4 beats from word 6.
`ifdef AXI_RD_SLV_WRAP_EN
      set_exp(0, 32'h1006, 2'b00); set_exp(1, 32'h1007, 2'b00);
      set_exp(2, 32'h1004, 2'b00); set_exp(3, 32'h1005, 2'b00);
`else
      for (int i = 0; i < 4; i++) set_exp(i, 32'd0, 2'b10);
`endif
      issue_ar(4'd1, BASE + 32'h18, 8'd3, 3'd2, 2'b10);
      run_burst(4'd1, 4, 4, 1'b0, "wrap4");

      // WRAP with an illegal length is always an error burst.
      for (int i = 0; i < 3; i++) set_exp(i, 32'd0, 2'b10);
      issue_ar(4'd9, BASE, 8'd2, 3'd2, 2'b10);
      run_burst(4'd9, 3, 3, 1'b0, "wrap_badlen");

      // INCR running off the end of memory.
      set_exp(0, 32'hAAAA_0FFE, 2'b00); set_exp(1, 32'hAAAA_0FFF, 2'b00);
      set_exp(2, 32'd0, 2'b10);         set_exp(3, 32'd0, 2'b10);
      issue_ar(4'd2, BASE + 32'((MEM_WORDS - 2) * 4), 8'd3, 3'd2, 2'b01);
      run_burst(4'd2, 4, 4, 1'b0, "edge");

      // FIXED burst repeats one word.
      for (int i = 0; i < 3; i++) set_exp(i, 32'h1003, 2'b00);
      issue_ar(4'd10, BASE + 32'hC, 8'd2, 3'd2, 2'b00);
      run_burst(4'd10, 3, 3, 1'b0, "fixed3");

      // Address below the base and a misaligned address both fail.
      set_exp(0, 32'd0, 2'b10);
      issue_ar(4'd11, BASE - 32'd4, 8'd0, 3'd2, 2'b01);
      run_burst(4'd11, 1, 1, 1'b0, "below_base");
      issue_ar(4'd12, BASE + 32'd2, 8'd0, 3'd2, 2'b01);
      run_burst(4'd12, 1, 1, 1'b0, "misaligned");

      // Bad arsize, with the next AR already waiting during the burst.
      set_exp(0, 32'd0, 2'b10); set_exp(1, 32'd0, 2'b10);
      issue_ar(4'd4, BASE, 8'd1, 3'd3, 2'b01);
      arid = 4'd6; araddr = BASE + 32'h8; arlen = 8'd0; arsize = 3'd2; arburst = 2'b00;
      arvalid = 1'b1;
      run_burst(4'd4, 2, 2, 1'b0, "badsize");
      set_exp(0, 32'h1002, 2'b00);
      issue_ar(4'd6, BASE + 32'h8, 8'd0, 3'd2, 2'b00);
      run_burst(4'd6, 1, 1, 1'b0, "fixed1");

      // Load-port write to the word being presented while stalled.
      @(posedge clk); #1;
      issue_ar(4'd13, BASE + 32'h30, 8'd0, 3'd2, 2'b01);
      rready = 1'b0; ld_we = 1'b1; ld_addr = 12'd12; ld_data = 32'hBEEF_0012;
      @(negedge clk);
      chk("ld_old_dat", rdata, 32'h100C);
      @(posedge clk); #1;
      ld_we = 1'b0; rready = 1'b1;
      @(negedge clk);
      chk("ld_new_dat", rdata, 32'hBEEF_0012);
      chk("ld_new_last", 32'(rlast), 32'd1);
      @(posedge clk); #1;
      rready = 1'b0;
      @(negedge clk);
      chk("ld_end_rvalid", 32'(rvalid), 32'd0);
      @(posedge clk); #1;

      // Reset after beat 5 of a 16-beat burst.
      for (int i = 0; i < 16; i++) set_exp(i, (i == 12) ? 32'hBEEF_0012 : 32'h1000 + 32'(i), 2'b00);
      issue_ar(4'd7, BASE, 8'd15, 3'd2, 2'b01);
      run_burst(4'd7, 6, 16, 1'b0, "pre_rst");
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_arready", 32'(arready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_rvalid", 32'(rvalid), 32'd0);
      chk("after_rst_arready", 32'(arready), 32'd1);
      set_exp(0, 32'h1009, 2'b00);
      issue_ar(4'd8, BASE + 32'h24, 8'd0, 3'd2, 2'b01);
      run_burst(4'd8, 1, 1, 1'b0, "post_rst_rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
